// File: rtl/dataflow_start_ctrl_if.sv
// Start/ready/done handshake bundle between an HLS dataflow region controller
// and its environment (top-level ap_* handshake plus per-process signals).
interface dataflow_start_ctrl_if #(
  parameter int NPROC        = 2,
  parameter int MAX_INFLIGHT = 2
) ();
  localparam int IW = $clog2(MAX_INFLIGHT + 1);

  logic             ap_start;
  logic             ap_ready;
  logic             ap_done;
  logic             ap_continue;
  logic             ap_idle;
  logic [NPROC-1:0] proc_start;
  logic [NPROC-1:0] proc_ready;
  logic [NPROC-1:0] proc_done;
  logic [NPROC-1:0] proc_idle;
  logic [NPROC-1:0] proc_continue;
  logic [NPROC-1:0] ready_count;
  logic [IW-1:0]    inflight;
  logic             err;
  logic             stall;

  // Environment side: issues starts/continues and reports process status.
  modport master (
    output ap_start, ap_continue, proc_ready, proc_done, proc_idle,
    input  ap_ready, ap_done, ap_idle, proc_start, proc_continue,
           ready_count, inflight, err, stall
  );

  // Controller side.
  modport slave (
    input  ap_start, ap_continue, proc_ready, proc_done, proc_idle,
    output ap_ready, ap_done, ap_idle, proc_start, proc_continue,
           ready_count, inflight, err, stall
  );
endinterface

// File: rtl/dataflow_start_ctrl.sv
// Start/ready/done sequencer for an NPROC-process HLS dataflow region.
// Optional stall watchdog enabled by defining DF_STALL_WATCHDOG_EN.
module dataflow_start_ctrl #(
  parameter int NPROC        = 2,
  parameter int MAX_INFLIGHT = 2,
  parameter int STALL_LIMIT  = 1024
) (
  input logic                  clock,
  input logic                  reset,
  dataflow_start_ctrl_if.slave df
);
  localparam int IW = $clog2(MAX_INFLIGHT + 1);

  logic [NPROC-1:0] ready_count_q, ready_count_d;
  logic [NPROC-1:0] done_cnt_q, done_cnt_d;
  logic [IW-1:0]    inflight_q, inflight_d;
  logic             err_q, err_d;

  logic [NPROC-1:0] proc_start, eff_rdy, eff_done;
  logic             full, start_ok, ap_ready, ap_done, retire;

  always_comb begin
    full       = (inflight_q == IW'(MAX_INFLIGHT));
    start_ok   = df.ap_start & ~full;
    // A process that already accepted this iteration is not started again.
    proc_start = {NPROC{start_ok}} & ~ready_count_q;
    eff_rdy    = ready_count_q | (df.proc_ready & proc_start);
    ap_ready   = start_ok & (&eff_rdy);

    eff_done   = done_cnt_q | df.proc_done;
    ap_done    = &eff_done;
    retire     = ap_done & df.ap_continue;

    ready_count_d = ready_count_q;
    if (ap_ready)      ready_count_d = '0;
    else if (start_ok) ready_count_d = eff_rdy;

    done_cnt_d = retire ? '0 : eff_done;

    inflight_d = inflight_q;
    if (ap_ready && !retire)
      inflight_d = inflight_q + IW'(1);
    else if (retire && !ap_ready && (inflight_q != '0))
      inflight_d = inflight_q - IW'(1);

    // Retiring with nothing outstanding is a protocol violation; saturate at 0.
    err_d = err_q | (retire & (inflight_q == '0));
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ready_count_q <= '0;
      done_cnt_q    <= '0;
      inflight_q    <= '0;
      err_q         <= 1'b0;
    end else begin
      ready_count_q <= ready_count_d;
      done_cnt_q    <= done_cnt_d;
      inflight_q    <= inflight_d;
      err_q         <= err_d;
    end
  end

  assign df.proc_start    = proc_start;
  assign df.ap_ready      = ap_ready;
  assign df.ap_done       = ap_done;
  assign df.proc_continue = {NPROC{retire}};
  assign df.ap_idle       = (inflight_q == '0) & ~df.ap_start & (&df.proc_idle);
  assign df.ready_count   = ready_count_q;
  assign df.inflight      = inflight_q;
  assign df.err           = err_q;

`ifdef DF_STALL_WATCHDOG_EN
  localparam int SW = $clog2(STALL_LIMIT + 1);

  logic [SW-1:0] wd_cnt_q, wd_cnt_d;
  logic          progress, active;

  always_comb begin
    progress = ap_ready | retire
             | (|(ready_count_d & ~ready_count_q))
             | (|(done_cnt_d & ~done_cnt_q));
    active   = df.ap_start | (inflight_q != '0);
    wd_cnt_d = wd_cnt_q;
    // An inactive region is not stalled, so the count restarts from zero.
    if (progress || !active)
      wd_cnt_d = '0;
    else if (wd_cnt_q != SW'(STALL_LIMIT))
      wd_cnt_d = wd_cnt_q + SW'(1);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) wd_cnt_q <= '0;
    else        wd_cnt_q <= wd_cnt_d;
  end

  assign df.stall = (wd_cnt_q == SW'(STALL_LIMIT));
`else
  // No watchdog: a constant-false flag that still references the limit.
  assign df.stall = (STALL_LIMIT < 0);
`endif
endmodule
